// File: rtl/sound_output_mixer_if.sv
// Signal bundle between the music players / game logic and the speaker mixer.
// master drives streams, triggers and controls; slave returns the speaker and status.
interface sound_output_mixer_if #(
    parameter int unsigned SFX_COUNT = 2,
    parameter int unsigned PWM_BITS  = 4,
    parameter int unsigned HOLD_BITS = 12
);
    localparam int unsigned IDX_BITS = (SFX_COUNT > 1) ? $clog2(SFX_COUNT) : 1;

    logic                 in_theme;
    logic [SFX_COUNT-1:0] sfx_in;
    logic [SFX_COUNT-1:0] sfx_trigger;
    logic [HOLD_BITS-1:0] sfx_hold_ms;
    logic [PWM_BITS-1:0]  theme_volume;
    logic                 mute;
    logic                 speaker_out;
    logic                 sfx_active;
    logic [IDX_BITS-1:0]  active_sfx_idx;

    modport master (
        output in_theme,
        output sfx_in,
        output sfx_trigger,
        output sfx_hold_ms,
        output theme_volume,
        output mute,
        input  speaker_out,
        input  sfx_active,
        input  active_sfx_idx
    );

    modport slave (
        input  in_theme,
        input  sfx_in,
        input  sfx_trigger,
        input  sfx_hold_ms,
        input  theme_volume,
        input  mute,
        output speaker_out,
        output sfx_active,
        output active_sfx_idx
    );
endinterface

// File: rtl/sound_output_mixer.sv
// Final audio stage: priority-arbitrated, timed sound effects override a PWM-scaled
// theme, with a silent release gap after each effect, driving one speaker pin.
module sound_output_mixer #(
    parameter int unsigned SFX_COUNT  = 2,
    parameter int unsigned PWM_BITS   = 4,
    parameter int unsigned HOLD_BITS  = 12,
    parameter int unsigned TICK_DIV   = 10000,
    parameter int unsigned RELEASE_MS = 20
) (
    input logic                clk10Mhz,
    input logic                reset_n,
    sound_output_mixer_if.slave bus
);
    localparam int unsigned IDX_BITS  = (SFX_COUNT > 1) ? $clog2(SFX_COUNT) : 1;
    localparam int unsigned TICK_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned REL_BITS  = $clog2(RELEASE_MS + 1);

    typedef enum logic [1:0] {
        StTheme,
        StSfx,
        StRelease
    } state_e;

    logic                 theme_s1_q, theme_s2_q;
    logic [SFX_COUNT-1:0] sfx_s1_q, sfx_s2_q;
    logic [TICK_BITS-1:0] tick_cnt_q;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic                 tick;
    logic                 pwm_gate;

    state_e               state_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic [HOLD_BITS-1:0] timer_q;
    logic [REL_BITS-1:0]  rel_timer_q;
    logic                 speaker_q;
    logic                 sfx_active_q;

    logic                 cand_valid;
    logic [IDX_BITS-1:0]  cand_idx;
    logic                 accept;
    logic                 mix;

    always_ff @(posedge clk10Mhz or negedge reset_n) begin
        if (!reset_n) begin
            theme_s1_q <= 1'b0;
            theme_s2_q <= 1'b0;
            sfx_s1_q   <= '0;
            sfx_s2_q   <= '0;
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            theme_s1_q <= bus.in_theme;
            theme_s2_q <= theme_s1_q;
            sfx_s1_q   <= bus.sfx_in;
            sfx_s2_q   <= sfx_s1_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
        end
    end

    assign tick     = (tick_cnt_q == TICK_BITS'(TICK_DIV - 1));
    assign pwm_gate = (&bus.theme_volume) | (pwm_cnt_q < bus.theme_volume);

    // Lowest asserted trigger index wins; descending loop leaves the lowest one.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        for (int i = SFX_COUNT - 1; i >= 0; i--) begin
            if (bus.sfx_trigger[i]) begin
                cand_valid = 1'b1;
                cand_idx   = IDX_BITS'(i);
            end
        end
    end

    assign accept = cand_valid && (bus.sfx_hold_ms != '0) &&
                    ((state_q != StSfx) || (cand_idx <= idx_q));

    always_comb begin
        mix = 1'b0;
        unique case (state_q)
            StTheme:   mix = theme_s2_q & pwm_gate;
            StSfx:     mix = sfx_s2_q[idx_q];
            StRelease: mix = 1'b0;
            default:   mix = 1'b0;
        endcase
    end

    // An accepted trigger takes precedence over any expiry in the same cycle.
    always_ff @(posedge clk10Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StTheme;
            idx_q        <= '0;
            timer_q      <= '0;
            rel_timer_q  <= '0;
            speaker_q    <= 1'b0;
            sfx_active_q <= 1'b0;
        end else begin
            speaker_q <= mix & ~bus.mute;
            if (accept) begin
                state_q      <= StSfx;
                sfx_active_q <= 1'b1;
                idx_q        <= cand_idx;
                timer_q      <= bus.sfx_hold_ms;
                rel_timer_q  <= '0;
            end else begin
                unique case (state_q)
                    StTheme: ;
                    StSfx: begin
                        if (tick) begin
                            timer_q <= timer_q - 1'b1;
                            if (timer_q == HOLD_BITS'(1)) begin
                                state_q      <= StRelease;
                                sfx_active_q <= 1'b0;
                                rel_timer_q  <= REL_BITS'(RELEASE_MS);
                            end
                        end
                    end
                    StRelease: begin
                        if (tick) begin
                            rel_timer_q <= rel_timer_q - 1'b1;
                            if (rel_timer_q == REL_BITS'(1)) begin
                                state_q <= StTheme;
                            end
                        end
                    end
                    default: begin
                        state_q      <= StTheme;
                        sfx_active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.speaker_out    = speaker_q;
    assign bus.sfx_active     = sfx_active_q;
    assign bus.active_sfx_idx = idx_q;
endmodule

// File: tb/tb_sound_output_mixer.sv
// Directed bench for sound_output_mixer with a short tick (10 cycles) and 2 ms release.
module tb_sound_output_mixer;
    localparam int unsigned SFX_COUNT  = 2;
    localparam int unsigned PWM_BITS   = 4;
    localparam int unsigned HOLD_BITS  = 12;
    localparam int unsigned TICK_DIV   = 10;
    localparam int unsigned RELEASE_MS = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic tog     = 1'b0;
    logic sfx1_prev = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sound_output_mixer_if #(
        .SFX_COUNT (SFX_COUNT),
        .PWM_BITS  (PWM_BITS),
        .HOLD_BITS (HOLD_BITS)
    ) bus ();

    sound_output_mixer #(
        .SFX_COUNT  (SFX_COUNT),
        .PWM_BITS   (PWM_BITS),
        .HOLD_BITS  (HOLD_BITS),
        .TICK_DIV   (TICK_DIV),
        .RELEASE_MS (RELEASE_MS)
    ) dut (
        .clk10Mhz (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; sfx_in[1] alternates every cycle while tog is set.
    task automatic step();
        @(negedge clk);
        sfx1_prev = bus.sfx_in[1];
        if (tog) bus.sfx_in[1] = ~bus.sfx_in[1];
    endtask

    task automatic fire(input logic [1:0] trig, input logic [11:0] hold);
        bus.sfx_trigger = trig;
        bus.sfx_hold_ms = hold;
        step();
        bus.sfx_trigger = '0;
    endtask

    initial begin
        logic [2:0] hist;
        logic       nv;
        int         errs;
        int         cnt;
        int         gap;

        bus.in_theme     = 1'b0;
        bus.sfx_in       = '0;
        bus.sfx_trigger  = '0;
        bus.sfx_hold_ms  = '0;
        bus.theme_volume = '0;
        bus.mute         = 1'b0;
        repeat (3) step();
        check_val("reset_speaker", int'(bus.speaker_out), 0);
        check_val("reset_active", int'(bus.sfx_active), 0);
        check_val("reset_idx", int'(bus.active_sfx_idx), 0);
        reset_n = 1'b1;

        // Full volume: speaker is in_theme delayed by 3 cycles.
        bus.theme_volume = 4'd15;
        hist = '0;
        errs = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (bus.speaker_out !== hist[2]) errs++;
            nv = ((n / 50) % 2 == 0);
            bus.in_theme = nv;
            hist = {hist[1:0], nv};
        end
        check_val("theme_follow_errs", errs, 0);

        bus.theme_volume = 4'd0;
        bus.in_theme = 1'b1;
        repeat (4) step();
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.speaker_out) cnt++;
        end
        check_val("vol0_highs", cnt, 0);

        bus.theme_volume = 4'd4;
        repeat (20) step();
        for (int w = 0; w < 2; w++) begin
            cnt = 0;
            for (int n = 0; n < 16; n++) begin
                step();
                if (bus.speaker_out) cnt++;
            end
            check_val($sformatf("pwm4_window%0d_highs", w), cnt, 4);
        end

        // Effect 1 alone: sfx_in[1] alternates, sfx_in[0] held high, theme at full volume.
        bus.theme_volume = 4'd15;
        bus.sfx_in = 2'b01;
        tog = 1'b1;
        repeat (6) step();
        fire(2'b10, 12'd3);
        check_val("sfx1_active", int'(bus.sfx_active), 1);
        check_val("sfx1_idx", int'(bus.active_sfx_idx), 1);
        cnt = 1;
        errs = 0;
        while (bus.sfx_active && cnt < 200) begin
            step();
            if (bus.sfx_active) begin
                cnt++;
                if (bus.speaker_out !== sfx1_prev) errs++;
            end
        end
        check_val($sformatf("sfx1_dur_21to30(%0d)", cnt), int'(cnt >= 21 && cnt <= 30), 1);
        check_val("sfx1_follow_errs", errs, 0);
        step();
        gap = 0;
        while (bus.speaker_out == 1'b0 && !bus.sfx_active && gap < 100) begin
            gap++;
            step();
        end
        check_val($sformatf("release_gap_11to20(%0d)", gap), int'(gap >= 11 && gap <= 20), 1);
        check_val("theme_resume_speaker", int'(bus.speaker_out), 1);
        check_val("theme_resume_active", int'(bus.sfx_active), 0);

        // Preemption by effect 0 reloads the hold; a later effect-1 trigger is ignored.
        fire(2'b10, 12'd3);
        repeat (4) step();
        fire(2'b01, 12'd5);
        check_val("preempt_idx", int'(bus.active_sfx_idx), 0);
        check_val("preempt_active", int'(bus.sfx_active), 1);
        cnt = 1;
        errs = 0;
        while (bus.sfx_active && cnt < 200) begin
            if (cnt == 10) begin
                bus.sfx_trigger = 2'b10;
                bus.sfx_hold_ms = 12'd7;
            end
            step();
            bus.sfx_trigger = '0;
            if (cnt == 10) check_val("lowprio_ignored_idx", int'(bus.active_sfx_idx), 0);
            if (bus.sfx_active) begin
                cnt++;
                if (bus.speaker_out !== 1'b1) errs++;
            end
        end
        check_val($sformatf("sfx0_dur_41to50(%0d)", cnt), int'(cnt >= 41 && cnt <= 50), 1);
        check_val("sfx0_follow_errs", errs, 0);
        repeat (25) step();

        fire(2'b10, 12'd0);
        check_val("hold0_ignored", int'(bus.sfx_active), 0);

        // Simultaneous triggers pick index 0; mute silences without touching timing.
        fire(2'b11, 12'd2);
        check_val("both_active", int'(bus.sfx_active), 1);
        check_val("both_idx", int'(bus.active_sfx_idx), 0);
        bus.mute = 1'b1;
        cnt = 1;
        errs = 0;
        while (bus.sfx_active && cnt < 200) begin
            step();
            if (bus.sfx_active) begin
                cnt++;
                if (bus.speaker_out) errs++;
            end
        end
        check_val("mute_highs", errs, 0);
        check_val($sformatf("mute_dur_11to20(%0d)", cnt), int'(cnt >= 11 && cnt <= 20), 1);
        repeat (25) step();
        bus.mute = 1'b0;

        // Asynchronous reset mid-effect, then tick phase restarts from zero.
        fire(2'b10, 12'd3);
        repeat (4) step();
        check_val("pre_reset_active", int'(bus.sfx_active), 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst_speaker", int'(bus.speaker_out), 0);
        check_val("async_rst_active", int'(bus.sfx_active), 0);
        check_val("async_rst_idx", int'(bus.active_sfx_idx), 0);
        step();
        reset_n = 1'b1;
        bus.sfx_trigger = 2'b10;
        bus.sfx_hold_ms = 12'd1;
        step();
        bus.sfx_trigger = '0;
        check_val("post_rst_quiet1", int'(bus.speaker_out), 0);
        cnt = bus.sfx_active ? 1 : 0;
        step();
        check_val("post_rst_quiet2", int'(bus.speaker_out), 0);
        if (bus.sfx_active) cnt++;
        while (bus.sfx_active && cnt < 100) begin
            step();
            if (bus.sfx_active) cnt++;
        end
        check_val("first_tick_hold1_dur", cnt, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
